// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: latches operands on start, processes one bit per
// clock LSB first, and publishes result, carry/borrow and signed overflow on completion.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             ai_s, bi_s, ax_s, sum_s, c_next_s;
  logic [WIDTH-1:0] acc_next_s;

  function automatic logic ovf_f(input logic sub, input logic am, input logic bm, input logic rm);
    ovf_f = (sub ? (am != bm) : (am == bm)) & (rm != am);
  endfunction

  // Subtraction reuses the full-adder carry with the minuend bit inverted (borrow chain).
  assign ai_s       = a_sh_q[0];
  assign bi_s       = b_sh_q[0];
  assign ax_s       = mode_q ? ~ai_s : ai_s;
  assign sum_s      = ai_s ^ bi_s ^ c_q;
  assign c_next_s   = (ax_s & bi_s) | (bi_s & c_q) | (c_q & ax_s);
  assign acc_next_s = {sum_s, acc_q[WIDTH-1:1]};

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    c_d      = c_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          c_d     = 1'b0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d  = acc_next_s;
        c_d    = c_next_s;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_next_s;
          cout_d   = c_next_s;
          ovf_d    = ovf_f(mode_q, a_msb_q, b_msb_q, sum_s);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      c_q      <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
